// File: rtl/bus_hold_arbiter_pkg.sv
// Shared types and helpers for the Z80 bus-hold arbiter.
// The watchdog build option is ARB_TIMEOUT_EN (see bus_hold_arbiter.sv).
package bus_hold_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUSREQ,
    SETTLE,
    GRANT,
    RELEASE,
    UNHOLD
  } arb_state_t;

  localparam int GUARD_DEF      = 2;
  localparam int MAX_TENURE_DEF = 255;

  // Rotate-priority search: first set bit upward from (last+1) mod nreq.
  // Returns {found, index}; the caller expands the index to one-hot.
  function automatic logic [2:0] rr_first(input logic [3:0]  req,
                                          input logic [1:0]  last,
                                          input int unsigned nreq);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = 2'((32'(last) + k) % nreq);
      if (k <= nreq && !pick[2] && req[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

endpackage

// File: rtl/bus_hold_arbiter_rr_pick.sv
// Combinational round-robin winner selection (req, last_grant -> one-hot winner).
module rr_pick
  import bus_hold_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last_grant,
  output logic [NREQ-1:0] winner,
  output logic [1:0]      winner_idx,
  output logic            found
);

  logic [3:0] req4;
  logic [2:0] pick;

  assign req4       = 4'(req);
  assign pick       = rr_first(req4, last_grant, NREQ);
  assign found      = pick[2];
  assign winner_idx = pick[1:0];
  assign winner     = found ? (NREQ'(1) << pick[1:0]) : '0;

endmodule

// File: rtl/bus_hold_arbiter.sv
// Z80 BUSRQ/BUSAK handshake, control-bus mux select and round-robin grant.
// Optional tenure watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_hold_arbiter
  import bus_hold_arbiter_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int GUARD      = GUARD_DEF,
  parameter int MAX_TENURE = MAX_TENURE_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            busak_n,
  output logic            busrq_n,
  output logic            ctl_select,
  output logic [NREQ-1:0] grant,
  output logic            timeout
);

  if (NREQ < 1 || NREQ > 4 || GUARD < 1 || GUARD > 15 ||
      MAX_TENURE < 1 || MAX_TENURE > 255) begin : g_param_check
    $error("bus_hold_arbiter: parameter out of range");
  end

  arb_state_t      state, state_nx;
  logic [3:0]      cnt, cnt_nx;
  logic [1:0]      owner, owner_nx;
  logic [1:0]      last_grant, last_nx;
  logic [NREQ-1:0] grant_nx;
  logic            busrq_nx, ctl_nx;
  logic            busak_p0, busak_p1;
  logic            ack;
  logic [NREQ-1:0] req_eff;
  logic [NREQ-1:0] winner;
  logic [1:0]      winner_idx;
  logic            found;
  logic            guard_done;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]      tenure, tenure_nx;
  logic            timeout_nx;
  logic [NREQ-1:0] blocked, blocked_nx;

  // A revoked requester stays masked until its req has been seen low.
  assign req_eff = req & ~blocked;
`else
  assign req_eff = req;
  assign timeout = 1'b0;
`endif

  assign ack        = ~busak_p1;
  assign guard_done = (cnt == 4'(GUARD - 1));

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req        (req_eff),
    .last_grant (last_grant),
    .winner     (winner),
    .winner_idx (winner_idx),
    .found      (found)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    owner_nx = owner;
    last_nx  = last_grant;
    grant_nx = grant;
`ifdef ARB_TIMEOUT_EN
    tenure_nx  = tenure;
    timeout_nx = 1'b0;
    blocked_nx = blocked & req;
`endif
    case (state)
      IDLE: begin
        grant_nx = '0;
        if (|req_eff) state_nx = BUSREQ;
      end
      BUSREQ: begin
        if (ack) begin
          state_nx = SETTLE;
          cnt_nx   = '0;
        end else if (!(|req_eff)) begin
          state_nx = UNHOLD;
        end
      end
      SETTLE: begin
        if (!ack) begin
          state_nx = UNHOLD;
          grant_nx = '0;
        end else if (guard_done) begin
          cnt_nx = '0;
          if (found) begin
            state_nx = GRANT;
            grant_nx = winner;
            owner_nx = winner_idx;
`ifdef ARB_TIMEOUT_EN
            tenure_nx = '0;
`endif
          end else begin
            state_nx = RELEASE;
          end
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      GRANT: begin
        // Only the owner's own request matters; others never preempt.
        if (!ack) begin
          state_nx = UNHOLD;
          grant_nx = '0;
        end else if (!(|(req & grant))) begin
          state_nx = RELEASE;
          grant_nx = '0;
          last_nx  = owner;
          cnt_nx   = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tenure == 8'(MAX_TENURE - 1)) begin
          state_nx   = RELEASE;
          grant_nx   = '0;
          last_nx    = owner;
          cnt_nx     = '0;
          timeout_nx = 1'b1;
          blocked_nx = blocked_nx | grant;
        end else begin
          tenure_nx = tenure + 8'd1;
        end
`endif
      end
      RELEASE: begin
        grant_nx = '0;
        if (!ack) begin
          state_nx = UNHOLD;
        end else if (guard_done) begin
          cnt_nx   = '0;
          state_nx = (|req_eff) ? SETTLE : UNHOLD;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      UNHOLD: begin
        grant_nx = '0;
        if (!ack) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state.
    busrq_nx = (state_nx == IDLE) || (state_nx == UNHOLD);
    ctl_nx   = (state_nx == SETTLE) || (state_nx == GRANT) || (state_nx == RELEASE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busak_p0   <= 1'b1;
      busak_p1   <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      owner      <= '0;
      last_grant <= 2'(NREQ - 1);
      busrq_n    <= 1'b1;
      ctl_select <= 1'b0;
      grant      <= '0;
    end else begin
      busak_p0   <= busak_n;
      busak_p1   <= busak_p0;
      state      <= state_nx;
      cnt        <= cnt_nx;
      owner      <= owner_nx;
      last_grant <= last_nx;
      busrq_n    <= busrq_nx;
      ctl_select <= ctl_nx;
      grant      <= grant_nx;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tenure  <= '0;
      timeout <= 1'b0;
      blocked <= '0;
    end else begin
      tenure  <= tenure_nx;
      timeout <= timeout_nx;
      blocked <= blocked_nx;
    end
  end
`endif

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Directed bench for bus_hold_arbiter with a simple Z80 BUSAK responder.
module tb_bus_hold_arbiter;

  localparam int NREQ       = 2;
  localparam int GUARD      = 2;
  localparam int MAX_TENURE = 20;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic            busak_n = 1'b1;
  logic            busrq_n;
  logic            ctl_select;
  logic [NREQ-1:0] grant;
  logic            timeout;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n;
  logic cpu_auto = 1'b1;
  logic cpu_force = 1'b1;
  logic [2:0] hist = 3'b111;
  logic rq_hi = 1'b0;
  logic gseen = 1'b0;

  bus_hold_arbiter #(.NREQ(NREQ), .GUARD(GUARD), .MAX_TENURE(MAX_TENURE)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .busak_n    (busak_n),
    .busrq_n    (busrq_n),
    .ctl_select (ctl_select),
    .grant      (grant),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // CPU model: BUSAK follows BUSRQ three falling edges later, or is forced.
  initial begin
    forever begin
      @(negedge clk);
      if (cpu_auto) begin
        hist    = {hist[1:0], busrq_n};
        busak_n = hist[2];
      end else begin
        hist    = 3'b111;
        busak_n = cpu_force;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (busrq_n) rq_hi = 1'b1;
    if (grant != '0) gseen = 1'b1;
  endtask

  task automatic wait_grant(input int budget, output int cycles);
    cycles = 0;
    while (grant == '0 && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (4) tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (4) tick();
    check("rst_busrq_n", 32'(busrq_n), 32'd1);
    check("rst_ctl", 32'(ctl_select), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_busrq_n", 32'(busrq_n), 32'd1);

    // Single request with full timing
    req = 2'b01;
    tick();
    check("t1_busrq_low", 32'(busrq_n), 32'd0);
    check("t1_ctl_early", 32'(ctl_select), 32'd0);
    repeat (4) tick();
    check("t1_ctl_pre_ack", 32'(ctl_select), 32'd0);
    tick();
    check("t1_ctl_rise", 32'(ctl_select), 32'd1);
    check("t1_no_grant_g0", 32'(grant), 32'd0);
    tick();
    check("t1_no_grant_g1", 32'(grant), 32'd0);
    tick();
    check("t1_grant", 32'(grant), 32'd1);
    repeat (10) tick();
    check("t1_grant_hold", 32'(grant), 32'd1);
    check("t1_timeout_idle", 32'(timeout), 32'd0);
    req = 2'b00;
    tick();
    check("t1_drop_grant", 32'(grant), 32'd0);
    check("t1_drop_ctl", 32'(ctl_select), 32'd1);
    check("t1_drop_busrq", 32'(busrq_n), 32'd0);
    tick();
    check("t1_guard_ctl", 32'(ctl_select), 32'd1);
    tick();
    check("t1_unhold_ctl", 32'(ctl_select), 32'd0);
    check("t1_unhold_busrq", 32'(busrq_n), 32'd1);
    repeat (10) tick();
    check("t1_idle_busrq", 32'(busrq_n), 32'd1);

    // Round robin with both requesting
    do_reset();
    req = 2'b11;
    wait_grant(30, n);
    check("t2_lat1", 32'(n), 32'd8);
    check("t2_grant1", 32'(grant), 32'd1);
    rq_hi = 1'b0;
    repeat (10) tick();
    req = 2'b10;
    tick();
    check("t2_drop1", 32'(grant), 32'd0);
    req = 2'b11;
    wait_grant(20, n);
    check("t2_lat2", 32'(n), 32'd4);
    check("t2_grant2", 32'(grant), 32'd2);
    repeat (10) tick();
    req = 2'b01;
    tick();
    check("t2_drop2", 32'(grant), 32'd0);
    req = 2'b11;
    wait_grant(20, n);
    check("t2_lat3", 32'(n), 32'd4);
    check("t2_grant3", 32'(grant), 32'd1);
    check("t2_busrq_held", 32'(rq_hi), 32'd0);
    req = 2'b00;
    repeat (15) tick();
    check("t2_end_busrq", 32'(busrq_n), 32'd1);
    check("t2_end_ctl", 32'(ctl_select), 32'd0);

    // Request withdrawn before BUSAK
    cpu_auto  = 1'b0;
    cpu_force = 1'b1;
    tick();
    gseen = 1'b0;
    req = 2'b01;
    tick();
    check("t3_busrq_low", 32'(busrq_n), 32'd0);
    req = 2'b00;
    tick();
    check("t3_busrq_back", 32'(busrq_n), 32'd1);
    repeat (6) tick();
    check("t3_ctl", 32'(ctl_select), 32'd0);
    check("t3_no_grant", 32'(gseen), 32'd0);

    // CPU drops BUSAK during GRANT
    cpu_auto = 1'b1;
    repeat (3) tick();
    req = 2'b01;
    wait_grant(30, n);
    check("t4_lat", 32'(n), 32'd8);
    check("t4_grant", 32'(grant), 32'd1);
    cpu_auto  = 1'b0;
    cpu_force = 1'b1;
    repeat (2) tick();
    check("t4_grant_sync", 32'(grant), 32'd1);
    tick();
    check("t4_fault_grant", 32'(grant), 32'd0);
    check("t4_fault_busrq", 32'(busrq_n), 32'd1);
    check("t4_fault_ctl", 32'(ctl_select), 32'd0);
    req = 2'b00;
    repeat (3) tick();
    check("t4_after_busrq", 32'(busrq_n), 32'd1);
    req = 2'b01;
    tick();
    check("t4_back_idle", 32'(busrq_n), 32'd0);
    req = 2'b00;
    repeat (3) tick();

    // Reset during GRANT
    cpu_auto = 1'b1;
    repeat (3) tick();
    req = 2'b01;
    wait_grant(30, n);
    check("t5_grant", 32'(grant), 32'd1);
    reset = 1'b1;
    tick();
    check("t5_busrq", 32'(busrq_n), 32'd1);
    check("t5_ctl", 32'(ctl_select), 32'd0);
    check("t5_grant_clr", 32'(grant), 32'd0);
    check("t5_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    req = 2'b00;
    repeat (8) tick();

`ifdef ARB_TIMEOUT_EN
    // Tenure watchdog revokes a stuck owner
    do_reset();
    repeat (3) tick();
    req = 2'b01;
    wait_grant(30, n);
    check("t6_grant", 32'(grant), 32'd1);
    n = 0;
    while (grant != '0 && n < 40) begin
      tick();
      n++;
    end
    check("t6_tenure", 32'(n), 32'd20);
    check("t6_timeout_pulse", 32'(timeout), 32'd1);
    tick();
    check("t6_timeout_clr", 32'(timeout), 32'd0);
    gseen = 1'b0;
    repeat (20) tick();
    check("t6_blocked", 32'(gseen), 32'd0);
    check("t6_blocked_busrq", 32'(busrq_n), 32'd1);
    req = 2'b00;
    tick();
    req = 2'b01;
    wait_grant(40, n);
    check("t6_regrant", 32'(grant), 32'd1);
    req = 2'b00;
    repeat (10) tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
